// File: rtl/shift_arbiter.sv
// shift_arbiter: two-port arbiter and sequencer for the shared RV64 shift
// datapath (SLL/SRL/SRA plus the 32-bit W variants). One request is accepted
// from IDLE, evaluated in EXEC, and its result is held in HOLD until the
// consumer takes it.
// Build option: define SHIFT_ARB_FIXED_PRIO_EN for fixed priority (port 0
// always wins contention); otherwise contention is resolved round-robin.
module shift_arbiter #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [1:0]      req0_op,
    input  logic            req0_word,
    input  logic [XLEN-1:0] req0_a,
    input  logic [XLEN-1:0] req0_b,
    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [1:0]      req1_op,
    input  logic            req1_word,
    input  logic [XLEN-1:0] req1_a,
    input  logic [XLEN-1:0] req1_b,
    output logic            res_valid,
    input  logic            res_ready,
    output logic            res_id,
    output logic [XLEN-1:0] res
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;

    logic [1:0]      state_q;
    logic [1:0]      state_d;
    logic            last_q;
    logic            id_q;
    logic [1:0]      op_q;
    logic            word_q;
    logic [XLEN-1:0] a_q;
    logic [5:0]      b_q;
    logic            res_valid_q;
    logic            res_id_q;
    logic [XLEN-1:0] res_q;

    logic            grant_id;
    logic            accept_en;
    logic [XLEN-1:0] shift_res;

    // Only the low six bits of a shift amount ever matter.
    logic unused_b_hi;
    assign unused_b_hi = ^{req0_b[XLEN-1:6], req1_b[XLEN-1:6]};

    // Pick the winning port: a lone valid wins outright; contention is
    // resolved by priority mode.
    always_comb begin
        grant_id = req1_valid;
        if (req0_valid && req1_valid) begin
`ifdef SHIFT_ARB_FIXED_PRIO_EN
            grant_id = 1'b0;
`else
            grant_id = ~last_q;
`endif
        end
    end

`ifdef SHIFT_ARB_FIXED_PRIO_EN
    // The pointer is still tracked so both builds share the same state.
    logic unused_last;
    assign unused_last = last_q;
`endif

    // Ready is suppressed during reset and depends only on state, valids
    // and the pointer (never on res_ready).
    assign accept_en  = !reset && (state_q == ST_IDLE) && (req0_valid || req1_valid);
    assign req0_ready = accept_en && !grant_id;
    assign req1_ready = accept_en &&  grant_id;

    // Shared shifter on the latched operands; W variants use a 5-bit
    // amount on the low word and sign-extend the 32-bit result.
    always_comb begin
        logic [5:0]      shamt;
        logic [XLEN-1:0] r64;
        logic [31:0]     r32;
        shamt = b_q;
        case (op_q)
            OP_SRL: begin
                r64 = a_q >> shamt;
                r32 = a_q[31:0] >> shamt[4:0];
            end
            OP_SRA: begin
                r64 = $unsigned($signed(a_q) >>> shamt);
                r32 = $unsigned($signed(a_q[31:0]) >>> shamt[4:0]);
            end
            default: begin
                r64 = a_q << shamt;
                r32 = a_q[31:0] << shamt[4:0];
            end
        endcase
        shift_res = word_q ? {{(XLEN-32){r32[31]}}, r32} : r64;
    end

    // Next-state logic for the IDLE -> EXEC -> HOLD sequence.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept_en) state_d = ST_EXEC;
            ST_EXEC: state_d = ST_HOLD;
            ST_HOLD: if (res_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State, operand latches and the result register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            last_q      <= 1'b1;
            id_q        <= 1'b0;
            op_q        <= 2'b00;
            word_q      <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            res_valid_q <= 1'b0;
            res_id_q    <= 1'b0;
            res_q       <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_IDLE: begin
                    if (accept_en) begin
                        last_q <= grant_id;
                        id_q   <= grant_id;
                        op_q   <= grant_id ? req1_op   : req0_op;
                        word_q <= grant_id ? req1_word : req0_word;
                        a_q    <= grant_id ? req1_a    : req0_a;
                        // W variants ignore bit 5 of the amount.
                        if (grant_id ? req1_word : req0_word)
                            b_q <= {1'b0, (grant_id ? req1_b[4:0] : req0_b[4:0])};
                        else
                            b_q <= grant_id ? req1_b[5:0] : req0_b[5:0];
                    end
                end
                ST_EXEC: begin
                    res_q       <= shift_res;
                    res_id_q    <= id_q;
                    res_valid_q <= 1'b1;
                end
                ST_HOLD: begin
                    if (res_ready) res_valid_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign res_valid = res_valid_q;
    assign res_id    = res_id_q;
    assign res       = res_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// Testbench for shift_arbiter: scoreboard of expected {id, result} pairs,
// pushed on acceptance and popped when the result handshake occurs.
module tb_shift_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req0_ready, req0_word;
    logic [1:0]  req0_op;
    logic [63:0] req0_a, req0_b;
    logic        req1_valid, req1_ready, req1_word;
    logic [1:0]  req1_op;
    logic [63:0] req1_a, req1_b;
    logic        res_valid, res_ready, res_id;
    logic [63:0] res;

    typedef struct {
        logic        id;
        logic [63:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    shift_arbiter #(.XLEN(64)) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_op    (req0_op),
        .req0_word  (req0_word),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_op    (req1_op),
        .req1_word  (req1_word),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_id     (res_id),
        .res        (res)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference shifter built from logical shifts plus an explicit sign mask.
    function automatic logic [63:0] model(input logic [1:0] op, input logic w,
                                          input logic [63:0] a, input logic [63:0] b);
        int          sh;
        logic [31:0] r32;
        logic [63:0] r64;
        if (w) begin
            sh = int'(b[4:0]);
            case (op)
                2'b01: r32 = a[31:0] >> sh;
                2'b10: begin
                    r32 = a[31:0] >> sh;
                    if (a[31]) r32 = r32 | ~(32'hFFFF_FFFF >> sh);
                end
                default: r32 = a[31:0] << sh;
            endcase
            r64 = {{32{r32[31]}}, r32};
        end else begin
            sh = int'(b[5:0]);
            case (op)
                2'b01: r64 = a >> sh;
                2'b10: begin
                    r64 = a >> sh;
                    if (a[63]) r64 = r64 | ~(64'hFFFF_FFFF_FFFF_FFFF >> sh);
                end
                default: r64 = a << sh;
            endcase
        end
        return r64;
    endfunction

    // Drive one request on a port (called at a negedge), wait for ready,
    // record the expected result and release valid after the accept edge.
    task automatic send(input int port, input logic [1:0] op, input logic w,
                        input logic [63:0] a, input logic [63:0] b, input logic [63:0] e);
        int cyc = 0;
        logic pid;
        pid = port[0];
        if (pid) begin
            req1_op = op; req1_word = w; req1_a = a; req1_b = b; req1_valid = 1'b1;
        end else begin
            req0_op = op; req0_word = w; req0_a = a; req0_b = b; req0_valid = 1'b1;
        end
        #1;
        while (!(pid ? req1_ready : req0_ready)) begin
            @(negedge clk); #1;
            cyc++;
            if (cyc > 50) begin
                check_val("accept_timeout", 64'd0, 64'd1);
                req0_valid = 1'b0; req1_valid = 1'b0;
                return;
            end
        end
        exp_q.push_back('{id: pid, val: e});
        @(posedge clk); #1;
        if (pid) req1_valid = 1'b0; else req0_valid = 1'b0;
    endtask

    task automatic drain();
        int c = 0;
        while (exp_q.size() != 0 && c < 100) begin
            @(negedge clk);
            c++;
        end
        check_val("drain", 64'(exp_q.size()), 64'd0);
    endtask

    // Result monitor: one line per completed result transaction.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && res_valid && res_ready) begin
            if (exp_q.size() == 0) begin
                check_val("unexpected_res", res, 64'hDEAD_DEAD_DEAD_DEAD);
            end else begin
                e = exp_q.pop_front();
                $display("txn id=%0d res=%h exp_id=%0d exp=%h", res_id, res, e.id, e.val);
                check_val("res_id", 64'(res_id), 64'(e.id));
                check_val("res", res, e.val);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        exp_grant[4];
        logic        g;
        logic [63:0] hold_res;
        logic        hold_id;
        logic        seen;
        int          cyc;

`ifdef SHIFT_ARB_FIXED_PRIO_EN
        exp_grant = '{1'b0, 1'b0, 1'b0, 1'b0};
`else
        exp_grant = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif
        // Reset with both valids up: ready must stay low.
        reset = 1'b1; res_ready = 1'b1;
        req0_valid = 1'b1; req0_op = 2'b00; req0_word = 1'b0; req0_a = 64'd1; req0_b = 64'd1;
        req1_valid = 1'b1; req1_op = 2'b00; req1_word = 1'b0; req1_a = 64'd1; req1_b = 64'd1;
        #3;
        check_val("rst_rdy0", 64'(req0_ready), 64'd0);
        check_val("rst_rdy1", 64'(req1_ready), 64'd0);
        check_val("rst_res_valid", 64'(res_valid), 64'd0);
        check_val("rst_res_id", 64'(res_id), 64'd0);
        check_val("rst_res", res, 64'd0);
        @(negedge clk); @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        reset = 1'b0;

        // SLL sweep on port 0 with latency checks.
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            send(0, 2'b00, 1'b0, 64'd1, 64'(i), 64'd1 << i);
            @(negedge clk);
            check_val("exec_lat", 64'(res_valid), 64'd0);
            @(negedge clk);
            check_val("hold_lat", 64'(res_valid), 64'd1);
        end
        drain();

        // Directed 64-bit and word vectors.
        @(negedge clk); send(0, 2'b10, 1'b0, 64'h8000_0000_0000_0000, 64'd4, 64'hF800_0000_0000_0000);
        drain();
        @(negedge clk); send(0, 2'b01, 1'b0, 64'h8000_0000_0000_0000, 64'd4, 64'h0800_0000_0000_0000);
        drain();
        @(negedge clk); send(1, 2'b00, 1'b1, 64'h1, 64'd31, 64'hFFFF_FFFF_8000_0000);
        drain();
        @(negedge clk); send(0, 2'b10, 1'b1, 64'h0000_0000_8000_0000, 64'h24, 64'hFFFF_FFFF_F800_0000);
        drain();
        @(negedge clk); send(1, 2'b01, 1'b1, 64'hFFFF_FFFF_8000_0000, 64'd1, 64'h0000_0000_4000_0000);
        drain();
        @(negedge clk); send(1, 2'b11, 1'b0, 64'h3, 64'hFFFF_FFFF_FFFF_FF44, 64'h30);
        drain();

        // Randomised ops against the model.
        for (int i = 0; i < 24; i++) begin
            logic [1:0]  op;
            logic        w;
            logic [63:0] a, b;
            op = 2'($urandom_range(0, 3));
            w  = 1'($urandom_range(0, 1));
            a  = {$urandom, $urandom};
            b  = {$urandom, $urandom};
            @(negedge clk);
            send(int'($urandom_range(0, 1)), op, w, a, b, model(op, w, a, b));
            drain();
        end

        // Contention: both ports valid continuously for four grants.
        @(negedge clk);
        req0_op = 2'b00; req0_word = 1'b0; req0_a = 64'd1;     req0_b = 64'd1;
        req1_op = 2'b01; req1_word = 1'b0; req1_a = 64'h100;  req1_b = 64'd4;
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cyc = 0;
            #1;
            while (!(req0_ready || req1_ready) && cyc < 50) begin
                @(negedge clk); #1;
                cyc++;
            end
            check_val("grant_wait", 64'(cyc >= 50), 64'd0);
            g = req1_ready;
            check_val("grant", 64'(g), 64'(exp_grant[k]));
            exp_q.push_back('{id: g, val: g ? 64'h10 : 64'h2});
            @(posedge clk);
            @(negedge clk);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        drain();

        // Backpressure: result held for 5 cycles with a request pending.
        res_ready = 1'b0;
        @(negedge clk);
        send(0, 2'b10, 1'b0, 64'h8000_0000_0000_0000, 64'd4, 64'hF800_0000_0000_0000);
        req1_op = 2'b00; req1_word = 1'b0; req1_a = 64'd3; req1_b = 64'd2; req1_valid = 1'b1;
        @(negedge clk);
        @(negedge clk);
        hold_res = res; hold_id = res_id;
        for (int i = 0; i < 5; i++) begin
            check_val("bp_valid", 64'(res_valid), 64'd1);
            check_val("bp_res", res, hold_res);
            check_val("bp_id", 64'(res_id), 64'(hold_id));
            check_val("bp_rdy0", 64'(req0_ready), 64'd0);
            check_val("bp_rdy1", 64'(req1_ready), 64'd0);
            @(negedge clk);
        end
        @(posedge clk); #1;
        res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_val("bp_valid_fall", 64'(res_valid), 64'd0);
        check_val("bp_next_rdy1", 64'(req1_ready), 64'd1);
        send(1, 2'b00, 1'b0, 64'd3, 64'd2, 64'd12);
        drain();

        // Reset during EXEC discards the in-flight request.
        @(negedge clk);
        send(1, 2'b00, 1'b0, 64'd5, 64'd3, 64'd40);
        drain();
        @(negedge clk);
        send(0, 2'b00, 1'b0, 64'd1, 64'd7, 64'h80);
        req0_valid = 1'b1;
        #2 reset = 1'b1;
        #1;
        check_val("arst_res_valid", 64'(res_valid), 64'd0);
        check_val("arst_res", res, 64'd0);
        check_val("arst_res_id", 64'(res_id), 64'd0);
        check_val("arst_rdy0", 64'(req0_ready), 64'd0);
        check_val("arst_rdy1", 64'(req1_ready), 64'd0);
        exp_q.delete();
        @(negedge clk);
        req0_valid = 1'b0;
        reset = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (res_valid) seen = 1'b1;
        end
        check_val("no_res_after_rst", 64'(seen), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
